img_frame_ctrl: RTL
===================

IMG_FRAME_CTRL -- requirements
Module: img_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 768, image width in pixels (even).
REQ-002 SHALL have parameter HEIGHT, default 512, image height in lines.
REQ-003 SHALL have parameter ARM_CYCLES, default 4, cycles source is held in reset before each frame (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 4096, maximum idle cycles between source beats during a frame.
REQ-005 SHALL have port HCLK  input  1  clock; all logic on posedge.
REQ-006 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  frame request, sampled per cycle.
REQ-008 SHALL have port abort  input  1  cancel current frame.
REQ-009 SHALL have ports cfg_op (input, 2), cfg_value (input, 8), cfg_sign (input, 1), cfg_thresh (input, 8): next-frame operation config (00 pass, 01 brightness, 10 invert, 11 threshold).
REQ-010 SHALL have port src_valid  input  1  source delivers one pixel pair this cycle.
REQ-011 SHALL have port src_done  input  1  source end-of-frame flag.
REQ-012 SHALL have port src_rst_n  output  1  active-low reset to pixel source.
REQ-013 SHALL have ports op_mode (output, 2), op_value (output, 8), op_sign (output, 1), op_thresh (output, 8): config latched for the running frame.
REQ-014 SHALL have ports busy (output, 1), frame_done (output, 1, pulse), err (output, 1, sticky), err_code (output, 2).
REQ-015 SHALL have ports line_cnt (output, 10, completed lines) and frame_cnt (output, 16, completed good frames).

Function
REQ-016 SHALL implement states IDLE, ARM, RUN, ERR.
REQ-017 IDLE: src_rst_n=0, busy=0; start=1 and abort=0 -> latch all cfg_* into op_*, clear err/err_code, clear beat and line counters, go ARM.
REQ-018 ARM: src_rst_n=0, busy=1; ARM_CYCLES cycles elapse -> RUN; src_rst_n=1 from first RUN cycle.
REQ-019 RUN: src_rst_n=1, busy=1; each src_valid=1 cycle increments a 19-bit beat counter; line_cnt increments on every WIDTH/2-th beat.
REQ-020 RUN: watchdog counter clears on src_valid=1, else increments; reaching TIMEOUT -> ERR with err_code=01.
REQ-021 RUN: src_done=1 -> frame good if beat count including any same-cycle beat equals HEIGHT*WIDTH/2; good -> frame_done=1 for one cycle, frame_cnt+1, go IDLE.
REQ-022 RUN: src_done=1 with beat count below HEIGHT*WIDTH/2 -> ERR, err_code=10 (short frame).
REQ-023 RUN: beat arriving after HEIGHT*WIDTH/2 beats already counted, without src_done -> ERR, err_code=11 (overrun); extra beat not counted.
REQ-024 ERR: src_rst_n=0, err=1, busy=1 for one cycle, then IDLE; err/err_code hold until next accepted start.
REQ-025 abort=1 in ARM or RUN -> IDLE next cycle, src_rst_n=0, no frame_done, frame_cnt unchanged, err unchanged.
REQ-026 abort has priority over start, src_done, timeout and overrun in the same cycle.
REQ-027 start while busy=1 SHALL be ignored (not queued); op_* SHALL not change during ARM/RUN.
REQ-028 frame_cnt SHALL wrap 65535 -> 0.
REQ-029 line_cnt SHALL hold its last value in IDLE/ERR until next accepted start.
REQ-030 All outputs SHALL be registered; frame_done asserts the cycle after src_done sampled.

Reset
REQ-031 HRESETn=0 SHALL asynchronously force IDLE, src_rst_n=0, busy=0, frame_done=0, err=0, err_code=00, line_cnt=0, frame_cnt=0, op_*=0, all internal counters 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse; operation resumes only on a new start after release.

Verification (WIDTH=8, HEIGHT=4, ARM_CYCLES=4, TIMEOUT=16)
REQ-033 start pulse with cfg_op=01, cfg_value=100, then 16 consecutive beats with src_done on beat 16 -> src_rst_n low 4 cycles, op_mode=01/op_value=100, line_cnt=4, one frame_done pulse, frame_cnt=1.
REQ-034 src_done after 12 beats -> err=1, err_code=10, frame_cnt unchanged, back in IDLE after one ERR cycle.
REQ-035 RUN with 16 cycles of no src_valid -> err_code=01, src_rst_n=0; subsequent good frame clears err and gives frame_cnt+1.
REQ-036 17th beat without src_done -> err_code=11, line_cnt=4.
REQ-037 abort and start asserted together during RUN at beat 5 -> IDLE, no frame_done, frame_cnt unchanged, start ignored; start in IDLE with new cfg_op=11 latches op_mode=11.
REQ-038 HRESETn pulsed low at beat 8 -> all outputs at reset values immediately, no frame_done after release.

Source files
------------

// File: rtl/img_frame_ctrl.sv
// img_frame_ctrl: per-frame sequencer for a pixel-pair source with arm, watchdog and frame-length checks.
module img_frame_ctrl #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int ARM_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  cfg_op,
    input  logic [7:0]  cfg_value,
    input  logic        cfg_sign,
    input  logic [7:0]  cfg_thresh,
    input  logic        src_valid,
    input  logic        src_done,
    output logic        src_rst_n,
    output logic [1:0]  op_mode,
    output logic [7:0]  op_value,
    output logic        op_sign,
    output logic [7:0]  op_thresh,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [9:0]  line_cnt,
    output logic [15:0] frame_cnt
);
    localparam logic [18:0] TOTAL    = 19'(HEIGHT * WIDTH / 2);
    localparam logic [18:0] LAST_COL = 19'(WIDTH / 2 - 1);
    localparam int AW = $clog2(ARM_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, ERR} state_t;
    state_t state;
    logic [18:0]   beat, col, beat_nxt;
    logic [AW-1:0] arm_cnt;
    logic [WW-1:0] wd;
    logic          full;

    always_comb begin
        beat_nxt = beat + 19'(src_valid);
        full     = beat == TOTAL;
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state      <= IDLE;
            src_rst_n  <= 1'b0;
            op_mode    <= '0;
            op_value   <= '0;
            op_sign    <= 1'b0;
            op_thresh  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
            line_cnt   <= '0;
            frame_cnt  <= '0;
            beat       <= '0;
            col        <= '0;
            arm_cnt    <= '0;
            wd         <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    state     <= ARM;
                    busy      <= 1'b1;
                    op_mode   <= cfg_op;
                    op_value  <= cfg_value;
                    op_sign   <= cfg_sign;
                    op_thresh <= cfg_thresh;
                    err       <= 1'b0;
                    err_code  <= '0;
                    beat      <= '0;
                    col       <= '0;
                    line_cnt  <= '0;
                    arm_cnt   <= '0;
                    wd        <= '0;
                end
                ARM: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (arm_cnt == ARM_LAST) begin
                    state     <= RUN;
                    src_rst_n <= 1'b1;
                    wd        <= '0;
                end else
                    arm_cnt <= arm_cnt + AW'(1);
                RUN: if (abort) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    src_rst_n <= 1'b0;
                end else begin
                    // a beat beyond the frame length is never counted
                    if (src_valid && !full) begin
                        beat <= beat_nxt;
                        col  <= (col == LAST_COL) ? '0 : col + 19'd1;
                        if (col == LAST_COL) line_cnt <= line_cnt + 10'd1;
                    end
                    wd <= src_valid ? '0 : wd + WW'(1);
                    if (src_done) begin
                        src_rst_n <= 1'b0;
                        if (beat_nxt == TOTAL) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end else begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= (beat_nxt < TOTAL) ? 2'b10 : 2'b11;
                        end
                    end else if (src_valid && full) begin
                        state     <= ERR;
                        src_rst_n <= 1'b0;
                        err       <= 1'b1;
                        err_code  <= 2'b11;
                    end else if (!src_valid && wd == WD_LAST) begin
                        state     <= ERR;
                        src_rst_n <= 1'b0;
                        err       <= 1'b1;
                        err_code  <= 2'b01;
                    end
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule
